// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory read port, applies EX-stage redirects and loads the IF/ID register,
// inserting bubbles whenever the in-flight fetch is killed or not yet returned.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX_CONTROL,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        STALL,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_PLUS_4,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID,
    output logic [1:0]  FETCH_STATE
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_WAIT = 2'd2,
        ILLEGAL    = 2'd3
    } fetchState_t;

    localparam logic [31:0] ALIGNED_RESET_PC = {RESET_PC[31:2], 2'b00};

    fetchState_t state_q;
    logic [31:0] pc_q;
    logic [31:0] pendingTarget_q;
    logic        imemRead_q;
    logic [31:0] ifIdPc_q;
    logic [31:0] ifIdPcPlus4_q;
    logic [31:0] ifIdInstr_q;
    logic        ifIdValid_q;

    logic [31:0] target_d;
    logic [31:0] pcPlus4_d;
    logic        unusedLsbs;

    // Word-aligned redirect target and sequential next PC (wraps modulo 2^32).
    assign target_d   = {BRANCH_OR_JUMP_ADDR[31:2], 2'b00};
    assign pcPlus4_d  = pc_q + 32'd4;
    assign unusedLsbs = ^BRANCH_OR_JUMP_ADDR[1:0];

    // Fetch FSM: PC, pending redirect target, read request and IF/ID register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q         <= BOOT;
            pc_q            <= ALIGNED_RESET_PC;
            pendingTarget_q <= 32'd0;
            imemRead_q      <= 1'b0;
            ifIdPc_q        <= 32'd0;
            ifIdPcPlus4_q   <= 32'd0;
            ifIdInstr_q     <= NOP_INSTR;
            ifIdValid_q     <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= FETCH;
                    imemRead_q <= 1'b1;
                end
                FETCH: begin
                    imemRead_q <= 1'b1;
                    if (PC_MUX_CONTROL && !IMEM_BUSYWAIT) begin
                        pc_q        <= target_d;
                        ifIdInstr_q <= NOP_INSTR;
                        ifIdValid_q <= 1'b0;
                    end else if (PC_MUX_CONTROL && IMEM_BUSYWAIT) begin
                        pendingTarget_q <= target_d;
                        ifIdInstr_q     <= NOP_INSTR;
                        ifIdValid_q     <= 1'b0;
                        state_q         <= REDIR_WAIT;
                    end else if (STALL || IMEM_BUSYWAIT) begin
                        if (IMEM_BUSYWAIT && !STALL) begin
                            ifIdInstr_q <= NOP_INSTR;
                            ifIdValid_q <= 1'b0;
                        end
                    end else begin
                        ifIdPc_q      <= pc_q;
                        ifIdPcPlus4_q <= pcPlus4_d;
                        ifIdInstr_q   <= IMEM_READDATA;
                        ifIdValid_q   <= 1'b1;
                        pc_q          <= pcPlus4_d;
                    end
                end
                REDIR_WAIT: begin
                    imemRead_q  <= 1'b1;
                    ifIdInstr_q <= NOP_INSTR;
                    ifIdValid_q <= 1'b0;
                    if (PC_MUX_CONTROL) begin
                        pendingTarget_q <= target_d;
                    end
                    if (!IMEM_BUSYWAIT) begin
                        pc_q    <= PC_MUX_CONTROL ? target_d : pendingTarget_q;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign IMEM_ADDR       = pc_q;
    assign IMEM_READ       = imemRead_q;
    assign IF_ID_PC        = ifIdPc_q;
    assign IF_ID_PC_PLUS_4 = ifIdPcPlus4_q;
    assign IF_ID_INSTR     = ifIdInstr_q;
    assign IF_ID_VALID     = ifIdValid_q;
    assign FETCH_STATE     = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed-vector bench for pc_fetch_unit. Instruction memory
// returns each word equal to its address; busywait is driven per cycle.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        PC_MUX_CONTROL;
    logic [31:0] BRANCH_OR_JUMP_ADDR;
    logic        STALL;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_PLUS_4;
    logic [31:0] IF_ID_INSTR;
    logic        IF_ID_VALID;
    logic [1:0]  FETCH_STATE;

    int errorCount;
    int checkCount;

    pc_fetch_unit dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .PC_MUX_CONTROL      (PC_MUX_CONTROL),
        .BRANCH_OR_JUMP_ADDR (BRANCH_OR_JUMP_ADDR),
        .STALL               (STALL),
        .IMEM_READDATA       (IMEM_READDATA),
        .IMEM_BUSYWAIT       (IMEM_BUSYWAIT),
        .IMEM_ADDR           (IMEM_ADDR),
        .IMEM_READ           (IMEM_READ),
        .IF_ID_PC            (IF_ID_PC),
        .IF_ID_PC_PLUS_4     (IF_ID_PC_PLUS_4),
        .IF_ID_INSTR         (IF_ID_INSTR),
        .IF_ID_VALID         (IF_ID_VALID),
        .FETCH_STATE         (FETCH_STATE)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory word equals its address.
    assign IMEM_READDATA = IMEM_ADDR;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, take the rising edge, settle 1 ns past it.
    task automatic applyStimulus(input logic rst, input logic mux, input logic [31:0] tgt,
                                 input logic stall, input logic busy);
        RESET               = rst;
        PC_MUX_CONTROL      = mux;
        BRANCH_OR_JUMP_ADDR = tgt;
        STALL               = stall;
        IMEM_BUSYWAIT       = busy;
        @(posedge CLK);
        #1;
    endtask

    // Directed scenario sequence with hand-computed expectations.
    initial begin
        errorCount = 0;
        checkCount = 0;

        // Reset held two cycles.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_state", 32'(FETCH_STATE), 32'd0);
        checkOutput("rst_addr", IMEM_ADDR, 32'h0);
        checkOutput("rst_read", 32'(IMEM_READ), 32'd0);
        checkOutput("rst_valid", 32'(IF_ID_VALID), 32'd0);
        checkOutput("rst_instr", IF_ID_INSTR, 32'h13);
        checkOutput("rst_pc", IF_ID_PC, 32'h0);
        checkOutput("rst_pc4", IF_ID_PC_PLUS_4, 32'h0);

        // BOOT -> FETCH, then sequential fetch 0,4,8.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("boot_state", 32'(FETCH_STATE), 32'd1);
        checkOutput("boot_addr", IMEM_ADDR, 32'h0);
        checkOutput("boot_read", 32'(IMEM_READ), 32'd1);
        checkOutput("boot_valid", 32'(IF_ID_VALID), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("seq0_addr", IMEM_ADDR, 32'h4);
        checkOutput("seq0_instr", IF_ID_INSTR, 32'h0);
        checkOutput("seq0_valid", 32'(IF_ID_VALID), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("seq1_addr", IMEM_ADDR, 32'h8);
        checkOutput("seq1_instr", IF_ID_INSTR, 32'h4);
        checkOutput("seq1_pc4", IF_ID_PC_PLUS_4, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre_stall_addr", IMEM_ADDR, 32'h10);

        // Stall three cycles at PC=0x10.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            checkOutput("stall_addr", IMEM_ADDR, 32'h10);
            checkOutput("stall_ifpc", IF_ID_PC, 32'hC);
            checkOutput("stall_valid", 32'(IF_ID_VALID), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("resume_ifpc", IF_ID_PC, 32'h10);
        checkOutput("resume_instr", IF_ID_INSTR, 32'h10);
        checkOutput("resume_addr", IMEM_ADDR, 32'h14);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre_redir_addr", IMEM_ADDR, 32'h20);

        // Redirect with memory ready, misaligned target.
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b0, 1'b0);
        checkOutput("redir_addr", IMEM_ADDR, 32'h100);
        checkOutput("redir_valid", 32'(IF_ID_VALID), 32'd0);
        checkOutput("redir_instr", IF_ID_INSTR, 32'h13);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("redir_ifpc", IF_ID_PC, 32'h100);
        checkOutput("redir_ifvalid", 32'(IF_ID_VALID), 32'd1);
        checkOutput("redir_next_addr", IMEM_ADDR, 32'h104);

        // Redirect beats a simultaneous stall.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        checkOutput("redir_stall_addr", IMEM_ADDR, 32'h40);
        checkOutput("redir_stall_valid", 32'(IF_ID_VALID), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("redir_stall_ifpc", IF_ID_PC, 32'h40);
        checkOutput("redir_stall_next", IMEM_ADDR, 32'h44);

        // Redirect while busy, overridden by a later redirect.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b1);
        checkOutput("busy1_state", 32'(FETCH_STATE), 32'd2);
        checkOutput("busy1_addr", IMEM_ADDR, 32'h44);
        checkOutput("busy1_valid", 32'(IF_ID_VALID), 32'd0);
        checkOutput("busy1_read", 32'(IMEM_READ), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
        checkOutput("busy2_addr", IMEM_ADDR, 32'h44);
        checkOutput("busy2_valid", 32'(IF_ID_VALID), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            checkOutput("busy_hold_state", 32'(FETCH_STATE), 32'd2);
            checkOutput("busy_hold_addr", IMEM_ADDR, 32'h44);
            checkOutput("busy_hold_valid", 32'(IF_ID_VALID), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("busy_done_addr", IMEM_ADDR, 32'h300);
        checkOutput("busy_done_state", 32'(FETCH_STATE), 32'd1);
        checkOutput("busy_done_valid", 32'(IF_ID_VALID), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("busy_first_ifpc", IF_ID_PC, 32'h300);
        checkOutput("busy_first_valid", 32'(IF_ID_VALID), 32'd1);

        // Plain busywait in FETCH: PC holds, IF/ID gets a bubble.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("fbusy_addr", IMEM_ADDR, 32'h304);
        checkOutput("fbusy_valid", 32'(IF_ID_VALID), 32'd0);
        checkOutput("fbusy_instr", IF_ID_INSTR, 32'h13);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("fbusy_ifpc", IF_ID_PC, 32'h304);
        checkOutput("fbusy_ifvalid", 32'(IF_ID_VALID), 32'd1);
        // Busywait together with stall: IF/ID holds its valid instruction.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("sbusy_addr", IMEM_ADDR, 32'h308);
        checkOutput("sbusy_ifpc", IF_ID_PC, 32'h304);
        checkOutput("sbusy_valid", 32'(IF_ID_VALID), 32'd1);

        // Wrap-around at the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        checkOutput("wrap0_addr", IMEM_ADDR, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap1_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap2_addr", IMEM_ADDR, 32'h0);
        checkOutput("wrap2_ifpc", IF_ID_PC, 32'hFFFF_FFFC);
        checkOutput("wrap2_pc4", IF_ID_PC_PLUS_4, 32'h0);

        // Reset in REDIR_WAIT with a redirect asserted.
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b1);
        checkOutput("mid_redir_state", 32'(FETCH_STATE), 32'd2);
        applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b1);
        checkOutput("mid_rst_state", 32'(FETCH_STATE), 32'd0);
        checkOutput("mid_rst_addr", IMEM_ADDR, 32'h0);
        checkOutput("mid_rst_valid", 32'(IF_ID_VALID), 32'd0);
        checkOutput("mid_rst_read", 32'(IMEM_READ), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_rst_state", 32'(FETCH_STATE), 32'd1);
        checkOutput("post_rst_addr", IMEM_ADDR, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_rst_ifpc", IF_ID_PC, 32'h0);
        checkOutput("post_rst_valid", 32'(IF_ID_VALID), 32'd1);
        checkOutput("post_rst_next", IMEM_ADDR, 32'h4);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
